// File: rtl/data_memory_port_pkg.sv
// Shared definitions for the data-side RAM port: size codes, FSM states,
// line geometry and the alignment rule.
package data_memory_port_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int OFFSET_W   = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_BAD  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FILL  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Size 3 has no legal alignment, so it is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size_e'(size))
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_port_line_lane_unit.sv
// Byte-lane steering between a 32-bit load/store value and a 128-bit line.
module line_lane_unit
  import data_memory_port_pkg::*;
(
  input  logic [LINE_BITS-1:0] line_i,
  input  logic [1:0]           size_i,
  input  logic [OFFSET_W-1:0]  offset_i,
  input  logic                 signed_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic [LINE_BITS-1:0] merged_o
);

  logic [OFFSET_W+2:0]   bit_off;
  logic [31:0]           lane_word;
  logic [LINE_BYTES-1:0] byte_mask;
  logic [LINE_BITS-1:0]  bit_mask;
  logic [LINE_BITS-1:0]  placed_wdata;

  assign bit_off = {offset_i, 3'b000};

  // Load path: bring the addressed bytes to bit 0 and extend to 32 bits.
  always_comb begin
    lane_word = 32'(line_i >> bit_off);
    rdata_o   = lane_word;
    case (size_e'(size_i))
      SIZE_BYTE: rdata_o = {{24{signed_i & lane_word[7]}}, lane_word[7:0]};
      SIZE_HALF: rdata_o = {{16{signed_i & lane_word[15]}}, lane_word[15:0]};
      default:   rdata_o = lane_word;
    endcase
  end

  // Store path: replace only the bytes covered by size at offset.
  always_comb begin
    case (size_e'(size_i))
      SIZE_BYTE: byte_mask = 16'h0001 << offset_i;
      SIZE_HALF: byte_mask = 16'h0003 << offset_i;
      default:   byte_mask = 16'h000F << offset_i;
    endcase
    bit_mask = '0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      bit_mask[8*b +: 8] = {8{byte_mask[b]}};
    end
    placed_wdata = {{(LINE_BITS-32){1'b0}}, wdata_i} << bit_off;
    merged_o     = (line_i & ~bit_mask) | (placed_wdata & bit_mask);
  end

endmodule

// File: rtl/data_memory_port.sv
// Load/store responder on RAM port b with a one-line read/merge/write buffer.
module data_memory_port
  import data_memory_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int RAM_WIDTH  = 128,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [31:0]           rsp_data,
  output logic                  rsp_misaligned,
  input  logic [RAM_WIDTH-1:0]  dout_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [RAM_WIDTH-1:0]  din_b,
  output logic                  we_b
);

  state_e                  state_q;
  logic                    req_write_q;
  logic                    req_signed_q;
  logic [1:0]              req_size_q;
  logic [OFFSET_W-1:0]     req_off_q;
  logic [31:0]             req_wdata_q;
  logic [TAG_WIDTH-1:0]    req_tag_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    buf_valid_q;
  logic [ADDR_WIDTH-1:0]   buf_line_q;
  logic [RAM_WIDTH-1:0]    buf_data_q;
  logic                    rsp_valid_q;
  logic                    rsp_mis_q;
  logic [31:0]             rsp_data_q;
  logic [TAG_WIDTH-1:0]    rsp_tag_q;

  logic [ADDR_WIDTH-1:0]   req_line_d;
  logic                    hit_d;
  logic [RAM_WIDTH-1:0]    lane_line_d;
  logic [1:0]              lane_size_d;
  logic [OFFSET_W-1:0]     lane_off_d;
  logic                    lane_signed_d;
  logic [31:0]             lane_rdata_d;
  logic [RAM_WIDTH-1:0]    lane_merged_d;

  assign req_line_d = {req_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign hit_d      = buf_valid_q && (buf_line_q == req_line_d);

  // One lane unit serves all paths: IDLE extracts a hit from the buffer
  // using the incoming request, FILL extracts from RAM data, WRITE merges.
  always_comb begin
    lane_line_d   = buf_data_q;
    lane_size_d   = req_size_q;
    lane_off_d    = req_off_q;
    lane_signed_d = req_signed_q;
    if (state_q == ST_IDLE) begin
      lane_size_d   = req_size;
      lane_off_d    = req_addr[OFFSET_W-1:0];
      lane_signed_d = req_signed;
    end else if (state_q == ST_FILL) begin
      lane_line_d = dout_b;
    end
  end

  line_lane_unit u_lane (
    .line_i   (lane_line_d),
    .size_i   (lane_size_d),
    .offset_i (lane_off_d),
    .signed_i (lane_signed_d),
    .wdata_i  (req_wdata_q),
    .rdata_o  (lane_rdata_d),
    .merged_o (lane_merged_d)
  );

  // Request sequencing, line buffer and registered response; rdy low freezes all of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_write_q  <= 1'b0;
      req_signed_q <= 1'b0;
      req_size_q   <= 2'd0;
      req_off_q    <= '0;
      req_wdata_q  <= '0;
      req_tag_q    <= '0;
      addr_q       <= '0;
      buf_valid_q  <= 1'b0;
      buf_line_q   <= '0;
      buf_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_mis_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
    end else if (rdy) begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_write_q  <= req_write;
            req_signed_q <= req_signed;
            req_size_q   <= req_size;
            req_off_q    <= req_addr[OFFSET_W-1:0];
            req_wdata_q  <= req_wdata;
            req_tag_q    <= req_tag;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              rsp_valid_q <= 1'b1;
              rsp_mis_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_tag_q   <= req_tag;
            end else if (hit_d && !req_write) begin
              rsp_valid_q <= 1'b1;
              rsp_mis_q   <= 1'b0;
              rsp_data_q  <= lane_rdata_d;
              rsp_tag_q   <= req_tag;
            end else begin
              addr_q  <= req_line_d;
              state_q <= hit_d ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_READ: state_q <= ST_FILL;
        ST_FILL: begin
          buf_data_q  <= dout_b;
          buf_valid_q <= 1'b1;
          buf_line_q  <= addr_q;
          if (req_write_q) begin
            state_q <= ST_WRITE;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_mis_q   <= 1'b0;
            rsp_data_q  <= lane_rdata_d;
            rsp_tag_q   <= req_tag_q;
            state_q     <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          buf_data_q  <= lane_merged_d;
          rsp_valid_q <= 1'b1;
          rsp_mis_q   <= 1'b0;
          rsp_data_q  <= '0;
          rsp_tag_q   <= req_tag_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A response held across a stall only becomes visible once rdy returns.
  assign rsp_valid      = rsp_valid_q & rdy;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_misaligned = rsp_mis_q;
  assign req_ready      = (state_q == ST_IDLE);

  assign addr_b = addr_q;
  assign din_b  = (state_q == ST_WRITE) ? lane_merged_d : buf_data_q;
  assign we_b   = (state_q == ST_WRITE) && rdy;

endmodule

// File: tb/tb_data_memory_port.sv
// Randomized bench for data_memory_port against a byte-array memory model.
module tb_data_memory_port;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_size;
  logic         req_signed;
  logic [16:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_tag;
  logic         rsp_valid;
  logic [3:0]   rsp_tag;
  logic [31:0]  rsp_data;
  logic         rsp_misaligned;
  logic [127:0] dout_b = '0;
  logic [16:0]  addr_b;
  logic [127:0] din_b;
  logic         we_b;

  logic [127:0] ram   [0:8191];
  logic [7:0]   model [0:131071];
  bit           m_valid;
  logic [16:0]  m_line;

  int n_chk = 0;
  int n_err = 0;

  data_memory_port dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_misaligned(rsp_misaligned),
    .dout_b(dout_b), .addr_b(addr_b), .din_b(din_b), .we_b(we_b)
  );

  always #5 clk = ~clk;

  // Registered-read RAM, read-before-write.
  always @(posedge clk) begin
    if (we_b) ram[addr_b[16:4]] <= din_b;
    dout_b <= ram[addr_b[16:4]];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_line(input logic [16:0] line);
    logic [127:0] v = '0;
    for (int b = 0; b < 16; b++) v[8*b +: 8] = model[int'(line) + b];
    return v;
  endfunction

  // One request end to end; stall > 0 drops rdy for that many cycles starting mid-FILL.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [16:0] ad, input logic [31:0] wd, input int stall);
    logic [3:0]   tg;
    logic [16:0]  line, rd_addr, we_addr;
    logic [31:0]  exp_data, got_data;
    logic [127:0] exp_line, we_din;
    logic [3:0]   got_tag;
    logic         got_mis;
    bit           mis, hit;
    int           nb, lat_exp, lat, we_cnt;
    tg       = 4'($urandom);
    line     = {ad[16:4], 4'h0};
    mis      = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'b00);
    hit      = m_valid && (m_line == line);
    nb       = 1 << sz;
    exp_data = '0;
    if (!mis && !wr) begin
      for (int i = 0; i < nb; i++) exp_data |= 32'(model[int'(ad) + i]) << (8 * i);
      if (sg && nb < 4 && exp_data[8*nb-1]) exp_data |= 32'hFFFF_FFFF << (8 * nb);
    end
    if (mis)      lat_exp = 1;
    else if (!wr) lat_exp = hit ? 1 : 3 + stall;
    else          lat_exp = hit ? 2 : 4 + stall;
    if (!mis && wr) begin
      for (int i = 0; i < nb; i++) model[int'(ad) + i] = wd[8*i +: 8];
    end
    exp_line = model_line(line);
    if (!mis && !hit) begin
      m_valid = 1'b1;
      m_line  = line;
    end

    @(negedge clk);
    check("rsp_pulse_end", 128'(rsp_valid), 128'(0));
    check("req_ready", 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd; req_tag = tg;
    lat = 0; we_cnt = 0; rd_addr = '0; we_addr = '0; we_din = '0;
    got_data = '0; got_tag = '0; got_mis = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rd_addr   = addr_b;
        req_valid = 1'b0;
      end
      if (we_b) begin
        we_cnt++;
        we_din  = din_b;
        we_addr = addr_b;
      end
      if (rsp_valid) begin
        lat      = k;
        got_data = rsp_data;
        got_tag  = rsp_tag;
        got_mis  = rsp_misaligned;
      end
      if (stall > 0 && k == 2) rdy = 1'b0;
      if (stall > 0 && k == 2 + stall) rdy = 1'b1;
    end
    rdy = 1'b1;
    check("latency", 128'(lat), 128'(lat_exp));
    check("rsp_data", 128'(got_data), 128'(exp_data));
    check("rsp_tag", 128'(got_tag), 128'(tg));
    check("rsp_misaligned", 128'(got_mis), 128'(mis));
    check("we_count", 128'(we_cnt), 128'((wr && !mis) ? 1 : 0));
    if (wr && !mis) begin
      check("we_din", we_din, exp_line);
      check("we_addr", 128'(we_addr), 128'(line));
    end
    if (!mis && !hit) check("read_addr", 128'(rd_addr), 128'(line));
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int b = 0; b < 16; b++) model[i*16 + b] = ram[i][8*b +: 8];
    end
    m_valid = 1'b0; m_line = '0;
    rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_we_b", 128'(we_b), 128'(0));
    check("rst_addr_b", 128'(addr_b), 128'(0));
    check("rst_din_b", din_b, 128'(0));
    check("rst_rsp_data", 128'(rsp_data), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(1));
    rst = 1'b0;

    // Directed cases.
    do_req(1'b1, 2'd2, 1'b0, 17'h00104, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 2'd0, 1'b1, 17'h00107, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 17'h00104, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 17'h00002, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 17'h00100, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 17'h0010F, 32'h0000_0011, 0);
    do_req(1'b1, 2'd0, 1'b0, 17'h0010F, 32'hAABB_CC5A, 0);
    do_req(1'b0, 2'd3, 1'b0, 17'h00100, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b1, 17'h00330, 32'h0, 3);
    do_req(1'b1, 2'd1, 1'b0, 17'h0044E, 32'h1234_8765, 2);

    // Reset in the middle of a store-hit WRITE cycle.
    do_req(1'b0, 2'd2, 1'b0, 17'h00200, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 17'h00208; req_wdata = 32'h1234_5678; req_tag = 4'hA;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_write_we", 128'(we_b), 128'(1));
    rst = 1'b1;
    #1;
    check("rstw_we_b", 128'(we_b), 128'(0));
    check("rstw_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rstw_addr_b", 128'(addr_b), 128'(0));
    check("rstw_din_b", din_b, 128'(0));
    check("rstw_rsp_tag", 128'(rsp_tag), 128'(0));
    check("rstw_rsp_data", 128'(rsp_data), 128'(0));
    check("rstw_rsp_mis", 128'(rsp_misaligned), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 17'h00208, 32'h0, 0);

    // Random traffic, mostly confined to a few lines so hits are common.
    for (int n = 0; n < 300; n++) begin
      logic [16:0] ad;
      if ($urandom_range(0, 3) == 0) ad = 17'($urandom());
      else ad = 17'h00100 + 17'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ad, $urandom(), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory_port.md
# data_memory_port

Load/store responder on RAM port b: accepts one aligned byte/half/word load or store from the load-store side and performs the line-wide read, merge, write sequence against the 128-bit RAM port. It is the write-capable counterpart of the read-only instruction path on port a. A one-entry line buffer serves repeat loads without a RAM read. RAM address space only; I/O is decoded elsewhere.

## Interface
- ADDR_WIDTH, 17, byte address width
- RAM_WIDTH, 128, RAM line width (16 bytes)
- TAG_WIDTH, 4, request tag width, echoed on response

- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global enable; low freezes all state
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word; 3 is illegal and treated as misaligned
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, low bytes used
- req_tag  in  TAG_WIDTH  opaque tag
- rsp_valid  out  1  one-cycle completion pulse
- rsp_tag  out  TAG_WIDTH  tag of completed request
- rsp_data  out  32  load result; 0 for stores
- rsp_misaligned  out  1  request rejected, no memory access
- dout_b  in  RAM_WIDTH  RAM read data, valid one cycle after addr_b
- addr_b  out  ADDR_WIDTH  line byte address, addr[3:0] = 0
- din_b  out  RAM_WIDTH  merged line to write
- we_b  out  1  write enable

## Operation
- Handshake: transfer when req_valid && req_ready && rdy. Request fields latched; one request in flight.
- Line address = req_addr with bits [3:0] cleared; offset = req_addr[3:0]. Byte k of line at bits [8k+7:8k].
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 3 → respond next cycle with rsp_misaligned=1, rsp_data=0; stay IDLE; buffer untouched.
- States: IDLE, READ, FILL, WRITE.
- IDLE: on accepted aligned request: buffer hit (valid and line match) load → respond next cycle; hit store → WRITE; miss → READ.
- READ: addr_b = line; we_b = 0 → FILL.
- FILL: capture dout_b into buffer, mark valid. Load → respond next cycle, IDLE. Store → WRITE.
- WRITE: we_b = 1, addr_b = line, din_b = buffer with size bytes at offset replaced by req_wdata; buffer updated with merged line; respond next cycle (rsp_data=0); IDLE.
- Load extract: size bytes at offset, zero- or sign-extended to 32 by req_signed.
- addr_b, din_b, we_b are combinational from state and latched registers; outside READ/WRITE we_b=0, addr_b holds last line, din_b holds buffer.
- rdy low: state, buffer, latched request frozen; we_b forced 0; rsp_valid held low and pending response issued after rdy returns; addr_b held stable so dout_b stays valid across a stall in FILL.
- Reset (any state, including mid-WRITE): state IDLE, buffer valid 0, buffer data 0, addr_b 0, din_b 0, we_b 0, rsp_valid 0, rsp_tag 0, rsp_data 0, rsp_misaligned 0. An interrupted request is dropped without response.

## Timing
- Accept cycle A. Misaligned or load hit: rsp_valid at A+1. Store hit: WRITE A+1, rsp A+2. Load miss: READ A+1, FILL A+2, rsp A+3. Store miss: READ A+1, FILL A+2, WRITE A+3, rsp A+4.
- req_ready low from A+1 until the cycle after the final state; a new request can be accepted in the rsp_valid cycle.
- Exactly one we_b pulse per store; none for loads or misaligned.

## Structure
- Shared package: size encodings, state enum, LINE_BYTES = 16, line-offset width 4.
- One sub-module, line_lane_unit: combinational extract (with sign/zero extend) and merge of a 32-bit value into a 128-bit line by size and offset.

## Test plan
- Store word 0xDEADBEEF to 0x00104 (miss) → READ addr_b 0x00100, we_b at A+3 with din_b[63:32]=0xDEADBEEF, others preserved, rsp at A+4.
- Then signed byte load 0x00107 → buffer hit, rsp_data 0xFFFFFFDE at A+1, no RAM read; unsigned half 0x00104 → 0x0000BEEF.
- Load word 0x00002 → rsp_misaligned=1 at A+1, we_b never asserts, buffer unchanged.
- Store byte 0x5A to 0x0010F with line preloaded 0x…11 → only din_b[127:120] changes to 0x5A.
- rdy low for 3 cycles during FILL of a load miss → correct data captured, rsp delayed 3 cycles, we_b 0 throughout.
- Assert rst during WRITE → we_b drops immediately, all outputs zero, next load of that line misses the buffer.
